// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   alu_op_e    : 4-bit opcode encoding (values 10-15 are reserved)
//   alu_state_e : control FSM states
//   LAT_*       : accept-to-done latencies in clock cycles
//   op_is_iter  : true for opcodes served by the iterative core
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_MOD = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_SLL = 4'd8,
    OP_SRL = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Single-cycle ops finish one cycle after accept; iterative ops need N
  // iteration cycles plus one commit cycle.
  localparam int LAT_SINGLE     = 1;
  localparam int LAT_ITER_EXTRA = 1;

  function automatic logic op_is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Iterative unsigned multiply / divide engine, one bit per clock.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start_i      : load operands and begin N iterations
//   div_i        : 1 = restoring division, 0 = shift-add multiply
//   a_i, b_i     : operand A, operand B
//   done_o       : one-cycle pulse after the last iteration
//   hi_o, lo_o   : mul -> product high/low; div -> remainder/quotient
module alu_iter_core #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         div_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         done_o,
  output logic [N-1:0] hi_o,
  output logic [N-1:0] lo_o
);

  localparam int CW = $clog2(N);

  logic          run_q;
  logic          done_q;
  logic          div_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  m_q;     // multiplicand (mul) or divisor (div)
  logic [N-1:0]  hi_q, hi_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [N:0]    sum;
  logic [N:0]    trial;

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    sum   = '0;
    trial = '0;
    if (div_q) begin
      // Shift the next dividend bit into the partial remainder, subtract
      // the divisor only if it fits.
      trial = {hi_q, lo_q[N-1]};
      if (trial >= {1'b0, m_q}) begin
        hi_d = trial[N-1:0] - m_q;
        lo_d = {lo_q[N-2:0], 1'b1};
      end else begin
        hi_d = trial[N-1:0];
        lo_d = {lo_q[N-2:0], 1'b0};
      end
    end else begin
      // Add multiplicand into the high half when the current multiplier bit
      // is set, then shift the whole {carry, hi, lo} right by one.
      sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(N+1){1'b0}});
      hi_d = sum[N:1];
      lo_d = {sum[0], lo_q[N-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      done_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      m_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        run_q <= 1'b1;
        cnt_q <= '0;
        div_q <= div_i;
        hi_q  <= '0;
        lo_q  <= div_i ? a_i : b_i;
        m_q   <= div_i ? b_i : a_i;
      end else if (run_q) begin
        hi_q <= hi_d;
        lo_q <= lo_d;
        if (cnt_q == CW'(N - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with start/busy/done handshake and registered flags.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request a new operation (ignored while busy)
//   A, B, S      : operands and 4-bit opcode
//   busy         : operation in progress
//   done         : one-cycle pulse, Q and flags newly valid
//   Q            : registered result
//   Ne, Z, V, C  : negative, zero, overflow, carry flags
module alu_seq
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   S,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Q,
  output logic         Ne,
  output logic         Z,
  output logic         V,
  output logic         C
);

  localparam logic [N-1:0] N_VAL = N'(N);

  alu_state_e   state_q;
  logic [N-1:0] a_q, b_q;
  logic [3:0]   op_q;
  logic         busy_q, done_q, ne_q, z_q, v_q, c_q;
  logic [N-1:0] q_q;

  logic         accept, core_start, core_done;
  logic [N-1:0] core_hi, core_lo;

  logic [N:0]   sum, dif, shl, shr;
  logic [N-1:0] res_q;
  logic         res_v, res_c;

  assign accept = start && (state_q == ST_IDLE);
  // Division by zero is resolved without iterating.
  assign core_start = accept && op_is_iter(S) && !((S != OP_MUL) && (B == '0));

  alu_iter_core #(.N(N)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (core_start),
    .div_i   (S != OP_MUL),
    .a_i     (A),
    .b_i     (B),
    .done_o  (core_done),
    .hi_o    (core_hi),
    .lo_o    (core_lo)
  );

  // Result selection for the commit cycle, from the latched operands.
  always_comb begin
    res_q = '0;
    res_v = 1'b0;
    res_c = 1'b0;
    sum   = {1'b0, a_q} + {1'b0, b_q};
    dif   = {1'b0, a_q} - {1'b0, b_q};
    shl   = {1'b0, a_q} << b_q;   // bit N holds the last bit shifted out
    shr   = {a_q, 1'b0} >> b_q;   // bit 0 holds the last bit shifted out
    if (state_q == ST_ITER) begin
      res_q = (op_q == OP_MOD) ? core_hi : core_lo;
      res_v = (op_q == OP_MUL) ? (|core_hi) : 1'b0;
    end else begin
      case (op_q)
        OP_ADD: begin
          res_q = sum[N-1:0];
          res_c = sum[N];
          res_v = (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1]);
        end
        OP_SUB: begin
          res_q = dif[N-1:0];
          res_c = ~dif[N];
          res_v = (a_q[N-1] != b_q[N-1]) && (dif[N-1] != a_q[N-1]);
        end
        OP_DIV: begin
          res_q = '1;
          res_v = 1'b1;
        end
        OP_MOD: begin
          res_q = a_q;
          res_v = 1'b1;
        end
        OP_AND: res_q = a_q & b_q;
        OP_OR:  res_q = a_q | b_q;
        OP_XOR: res_q = a_q ^ b_q;
        OP_SLL: begin
          if (b_q < N_VAL) begin
            res_q = shl[N-1:0];
            res_c = shl[N];
          end
        end
        OP_SRL: begin
          if (b_q < N_VAL) begin
            res_q = shr[N:1];
            res_c = shr[0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      ne_q    <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= S;
            busy_q  <= 1'b1;
            state_q <= core_start ? ST_ITER : ST_DONE;
          end
        end
        ST_ITER, ST_DONE: begin
          if ((state_q == ST_DONE) || core_done) begin
            q_q     <= res_q;
            ne_q    <= res_q[N-1];
            z_q     <= (res_q == '0);
            v_q     <= res_v;
            c_q     <= res_c;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Q    = q_q;
  assign Ne   = ne_q;
  assign Z    = z_q;
  assign V    = v_q;
  assign C    = c_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_pkg::*;

  localparam int N = 8;
  localparam int LAT_I = N + LAT_ITER_EXTRA;

  logic         clk, rst_n, start;
  logic [N-1:0] A, B, Q;
  logic [3:0]   S;
  logic         busy, done, Ne, Z, V, C;

  int errors = 0;
  int total  = 0;

  typedef struct {
    logic [7:0] q;
    logic       ne, z, v, c;
    int         lat;
  } exp_t;

  exp_t sb[$];

  alu_seq #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .S     (S),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .Ne    (Ne),
    .Z     (Z),
    .V     (V),
    .C     (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model built from plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ia, ib, sa, sbv, r;
    ia = int'(a);
    ib = int'(b);
    sa = int'($signed(a));
    sbv = int'($signed(b));
    e.q = 8'h00; e.v = 1'b0; e.c = 1'b0; e.lat = LAT_SINGLE;
    case (op)
      4'd0: begin
        r = ia + ib; e.q = r[7:0]; e.c = (r > 255);
        r = sa + sbv; e.v = (r > 127) || (r < -128);
      end
      4'd1: begin
        r = ia - ib; e.q = r[7:0]; e.c = (ia >= ib);
        r = sa - sbv; e.v = (r > 127) || (r < -128);
      end
      4'd2: begin
        r = ia * ib; e.q = r[7:0]; e.v = (r > 255); e.lat = LAT_I;
      end
      4'd3: begin
        if (ib == 0) begin e.q = 8'hFF; e.v = 1'b1; end
        else begin r = ia / ib; e.q = r[7:0]; e.lat = LAT_I; end
      end
      4'd4: begin
        if (ib == 0) begin e.q = a; e.v = 1'b1; end
        else begin r = ia % ib; e.q = r[7:0]; e.lat = LAT_I; end
      end
      4'd5: e.q = a & b;
      4'd6: e.q = a | b;
      4'd7: e.q = a ^ b;
      4'd8: begin
        if (ib < 8) begin
          r = ia << ib; e.q = r[7:0]; e.c = (ib == 0) ? 1'b0 : r[8];
        end
      end
      4'd9: begin
        if (ib < 8) begin
          r = ia >> ib; e.q = r[7:0];
          r = (ib == 0) ? 0 : ((ia >> (ib - 1)) & 1);
          e.c = r[0];
        end
      end
      default: ;
    endcase
    e.z  = (e.q == 8'h00);
    e.ne = e.q[7];
    return e;
  endfunction

  task automatic check_result(input string tag, input int lat);
    exp_t e;
    e = sb.pop_front();
    chk({tag, ".lat"}, lat, e.lat);
    chk({tag, ".q"}, Q, e.q);
    chk({tag, ".ne"}, Ne, e.ne);
    chk({tag, ".z"}, Z, e.z);
    chk({tag, ".v"}, V, e.v);
    chk({tag, ".c"}, C, e.c);
    chk({tag, ".busy_at_done"}, busy, 0);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int lat;
    bit got;
    @(negedge clk);
    A = a; B = b; S = op; start = 1'b1;
    sb.push_back(model(op, a, b));
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy"}, busy, 1);
    lat = 0; got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(posedge clk); #1;
      if (done) begin got = 1'b1; lat = c; end
    end
    check_result(tag, lat);
  endtask

  initial begin
    int dcnt, dlat;
    logic [7:0] qsave;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; S = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.q", Q, 0);
    chk("rst.ne", Ne, 0);
    chk("rst.z", Z, 0);
    chk("rst.v", V, 0);
    chk("rst.c", C, 0);
    @(negedge clk); rst_n = 1'b1;

    run_op("add7f01", OP_ADD, 8'h7F, 8'h01);
    run_op("mul15x17", OP_MUL, 8'd15, 8'd17);
    run_op("mul16x16", OP_MUL, 8'd16, 8'd16);
    qsave = Q;
    repeat (3) @(posedge clk);
    #1;
    chk("hold.q", Q, qsave);
    chk("hold.z", Z, 1);
    chk("hold.done", done, 0);
    run_op("div100_7", OP_DIV, 8'd100, 8'd7);
    run_op("mod100_7", OP_MOD, 8'd100, 8'd7);
    run_op("div5_0", OP_DIV, 8'd5, 8'd0);
    run_op("mod9_0", OP_MOD, 8'd9, 8'd0);
    run_op("divff_1", OP_DIV, 8'hFF, 8'd1);
    run_op("mulffff", OP_MUL, 8'hFF, 8'hFF);
    run_op("and", OP_AND, 8'hF0, 8'h3C);
    run_op("or", OP_OR, 8'hA0, 8'h05);
    run_op("xor", OP_XOR, 8'hAA, 8'hAA);
    run_op("srl80_8", OP_SRL, 8'h80, 8'd8);
    run_op("srl81_7", OP_SRL, 8'h81, 8'd7);
    run_op("sll81_0", OP_SLL, 8'h81, 8'd0);
    run_op("sll01_8", OP_SLL, 8'h01, 8'd8);
    run_op("sub80_01", OP_SUB, 8'h80, 8'h01);
    run_op("rsv12", 4'd12, 8'hFF, 8'hFF);

    // Start pulses while a multiply is running must be ignored.
    @(negedge clk);
    A = 8'd3; B = 8'd5; S = OP_MUL; start = 1'b1;
    sb.push_back(model(OP_MUL, 8'd3, 8'd5));
    @(posedge clk); #1;
    start = 1'b0; A = 8'hFF; B = 8'hFF; S = OP_ADD;
    dcnt = 0; dlat = 0;
    for (int c = 1; c <= N + 4; c++) begin
      @(posedge clk); #1;
      if (done) begin
        dcnt++;
        if (dcnt == 1) check_result("pulse", c);
        dlat = c;
      end
      start = (c < N) ? c[0] : 1'b0;
    end
    chk("pulse.done_count", dcnt, 1);
    chk("pulse.busy_after", busy, 0);

    // Start held high across done: second op accepted in the done cycle.
    @(negedge clk);
    A = 8'd1; B = 8'd2; S = OP_ADD; start = 1'b1;
    sb.push_back(model(OP_ADD, 8'd1, 8'd2));
    @(posedge clk); #1;
    A = 8'd10; B = 8'd20;
    sb.push_back(model(OP_ADD, 8'd10, 8'd20));
    @(posedge clk); #1;
    chk("b2b.done1", done, 1);
    check_result("b2b.first", 1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b.accept_busy", busy, 1);
    chk("b2b.accept_done", done, 0);
    @(posedge clk); #1;
    chk("b2b.done2", done, 1);
    check_result("b2b.second", 1);

    run_op("sub3_5", OP_SUB, 8'd3, 8'd5);

    // Reset in the middle of a division.
    @(negedge clk);
    A = 8'd200; B = 8'd3; S = OP_DIV; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    chk("midrst.q", Q, 0);
    chk("midrst.ne", Ne, 0);
    chk("midrst.z", Z, 0);
    chk("midrst.v", V, 0);
    chk("midrst.c", C, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    dcnt = 0;
    for (int c = 0; c < N + 4; c++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("midrst.no_done", dcnt, 0);
    run_op("sll81_1", OP_SLL, 8'h81, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule
